// File: rtl/bpu_pkg.sv
// bpu_pkg: types and constants shared between the branch predictor front end
// and the back-end resolve block.
package bpu_pkg;

  localparam logic [31:0] BPU_RESET_PC = 32'h1c00_0000;

  typedef struct packed {
    logic [31:0] npc;
  } bpu_predict_info_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        mispredict;
  } bpu_update_info_t;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    DRAIN
  } bpu_resolve_state_e;

endpackage

// File: rtl/bpu_update_fifo.sv
// bpu_update_fifo: circular buffer of predictor training records.
//   push/push_data : enqueue, ignored when full
//   pop            : dequeue, ignored when empty
//   head           : oldest entry, zero when empty
//   full/empty     : derived from registered pointers only
module bpu_update_fifo
  import bpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  bpu_update_info_t push_data,
  input  logic             pop,
  output bpu_update_info_t head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [AW:0]      count;
  logic             push_en;
  logic             pop_en;
  bpu_update_info_t mem [DEPTH];

  assign count   = wptr_q - rptr_q;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = empty ? '0 : mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + 1'b1;
      if (pop_en)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bpu_resolve.sv
// bpu_resolve: compares resolved branch outcomes against the prediction that
// travelled with each instruction, issues a one-cycle redirect/flush on a
// misprediction, and queues training records for the fetch-side predictor.
//   ex_*           : resolved instruction from execute
//   stall_o        : update FIFO full, upstream holds
//   redirect_o/pc  : fetch restart request, flush_o kills younger work
//   update_*       : valid/ready drain of training records
// Optional feature macro BPU_RESOLVE_PERF_EN adds saturating counters
// perf_branch_o and perf_mispred_o.
module bpu_resolve
  import bpu_pkg::*;
#(
  parameter int unsigned UPD_DEPTH   = 4,
  parameter int unsigned KILL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_i,
  input  logic [31:0]       ex_pc_i,
  input  logic              ex_is_branch_i,
  input  logic              ex_taken_i,
  input  logic [31:0]       ex_target_i,
  input  bpu_predict_info_t ex_pred_i,
  output logic              stall_o,
  output logic              redirect_o,
  output logic [31:0]       redirect_pc_o,
  output logic              flush_o,
  output logic              update_valid_o,
  output bpu_update_info_t  update_o,
  input  logic              update_ready_i
`ifdef BPU_RESOLVE_PERF_EN
  ,
  output logic [31:0]       perf_branch_o,
  output logic [31:0]       perf_mispred_o
`endif
);

  localparam int unsigned KW = $clog2(KILL_CYCLES + 1);

  bpu_resolve_state_e state_q, state_d;
  logic [KW-1:0]      kill_q, kill_d;
  logic [31:0]        redirect_pc_q;
  logic [31:0]        actual_npc;
  logic               accept;
  logic               mispredict;
  logic               push;
  logic               fifo_full;
  logic               fifo_empty;
  bpu_update_info_t   rec;

  assign accept     = ex_valid_i && !fifo_full && (state_q == IDLE);
  assign actual_npc = (ex_is_branch_i && ex_taken_i) ? ex_target_i : ex_pc_i + 32'd4;
  assign mispredict = (actual_npc != ex_pred_i.npc);
  assign push       = accept && (ex_is_branch_i || mispredict);

  assign rec.pc         = ex_pc_i;
  assign rec.target     = actual_npc;
  assign rec.taken      = ex_is_branch_i && ex_taken_i;
  assign rec.mispredict = mispredict;

  bpu_update_fifo #(
    .DEPTH(UPD_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(rec),
    .pop      (update_valid_o && update_ready_i),
    .head     (update_o),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign stall_o        = fifo_full;
  assign update_valid_o = !fifo_empty;
  assign redirect_o     = (state_q == REDIRECT);
  assign flush_o        = (state_q == REDIRECT);
  assign redirect_pc_o  = redirect_pc_q;

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    case (state_q)
      IDLE:     if (accept && mispredict) state_d = REDIRECT;
      REDIRECT: begin
        state_d = DRAIN;
        kill_d  = KW'(KILL_CYCLES);
      end
      DRAIN: begin
        if (kill_q == KW'(1)) state_d = IDLE;
        else                  kill_d  = kill_q - 1'b1;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      kill_q        <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (accept && mispredict) redirect_pc_q <= actual_npc;
    end
  end

`ifdef BPU_RESOLVE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branch_o  <= '0;
      perf_mispred_o <= '0;
    end else begin
      if (accept && ex_is_branch_i && perf_branch_o != '1)
        perf_branch_o <= perf_branch_o + 32'd1;
      if (accept && mispredict && perf_mispred_o != '1)
        perf_mispred_o <= perf_mispred_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpu_resolve.sv
// tb_bpu_resolve: directed scenarios plus randomized traffic checked against
// a queue-based reference model of the resolve block.
module tb_bpu_resolve;
  import bpu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned KILL  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              ex_valid_i = 1'b0;
  logic [31:0]       ex_pc_i = '0;
  logic              ex_is_branch_i = 1'b0;
  logic              ex_taken_i = 1'b0;
  logic [31:0]       ex_target_i = '0;
  bpu_predict_info_t ex_pred_i = '0;
  logic              stall_o;
  logic              redirect_o;
  logic [31:0]       redirect_pc_o;
  logic              flush_o;
  logic              update_valid_o;
  bpu_update_info_t  update_o;
  logic              update_ready_i = 1'b0;
`ifdef BPU_RESOLVE_PERF_EN
  logic [31:0]       perf_branch_o;
  logic [31:0]       perf_mispred_o;
`endif

  bpu_resolve #(
    .UPD_DEPTH  (DEPTH),
    .KILL_CYCLES(KILL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid_i    (ex_valid_i),
    .ex_pc_i       (ex_pc_i),
    .ex_is_branch_i(ex_is_branch_i),
    .ex_taken_i    (ex_taken_i),
    .ex_target_i   (ex_target_i),
    .ex_pred_i     (ex_pred_i),
    .stall_o       (stall_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .flush_o       (flush_o),
    .update_valid_o(update_valid_o),
    .update_o      (update_o),
    .update_ready_i(update_ready_i)
`ifdef BPU_RESOLVE_PERF_EN
    ,
    .perf_branch_o (perf_branch_o),
    .perf_mispred_o(perf_mispred_o)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: pending records, cycles still to ignore, redirect pulse.
  bpu_update_info_t m_q[$];
  int unsigned      m_ignore = 0;
  bit               m_redir = 0;
  logic [31:0]      m_rpc = '0;
  logic [31:0]      m_br = '0;
  logic [31:0]      m_mis = '0;
  bit               m_acc = 0;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bpu_update_info_t mk(input logic [31:0] pc, input logic [31:0] tgt,
                                          input logic tk, input logic mis);
    bpu_update_info_t r;
    r.pc = pc; r.target = tgt; r.taken = tk; r.mispredict = mis;
    return r;
  endfunction

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input bit v, input logic [31:0] pc, input bit br, input bit tk,
                      input logic [31:0] tgt, input logic [31:0] npc, input bit rdy);
    logic [31:0] act;
    bit          mis;
    ex_valid_i = v; ex_pc_i = pc; ex_is_branch_i = br; ex_taken_i = tk;
    ex_target_i = tgt; ex_pred_i.npc = npc; update_ready_i = rdy;
    @(negedge clk);
    check("stall", stall_o, m_q.size() == DEPTH);
    check("upd_valid", update_valid_o, m_q.size() != 0);
    check("upd_data", update_o, (m_q.size() != 0) ? m_q[0] : '0);
    check("redirect", redirect_o, m_redir);
    check("flush", flush_o, m_redir);
    if (m_redir) check("redirect_pc", redirect_pc_o, m_rpc);
`ifdef BPU_RESOLVE_PERF_EN
    check("perf_br", perf_branch_o, m_br);
    check("perf_mis", perf_mispred_o, m_mis);
`endif
    m_acc = v && (m_q.size() != DEPTH) && (m_ignore == 0);
    act = (br && tk) ? tgt : pc + 32'd4;
    mis = (act != npc);
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (m_acc && (br || mis)) m_q.push_back(mk(pc, act, br && tk, mis));
    if (m_acc && br && m_br != '1) m_br++;
    if (m_acc && mis && m_mis != '1) m_mis++;
    if (m_ignore > 0) m_ignore--;
    m_redir = m_acc && mis;
    if (m_redir) begin
      m_ignore = 1 + KILL;
      m_rpc = act;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ex_valid_i = 1'b0;
    update_ready_i = 1'b0;
    #1;
    check("rst_stall", stall_o, 0);
    check("rst_redirect", redirect_o, 0);
    check("rst_flush", flush_o, 0);
    check("rst_redirect_pc", redirect_pc_o, 0);
    check("rst_upd_valid", update_valid_o, 0);
    check("rst_upd_data", update_o, 0);
    m_q.delete();
    m_ignore = 0; m_redir = 0; m_br = '0; m_mis = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n, input bit rdy);
    for (int unsigned i = 0; i < n; i++) step(0, '0, 0, 0, '0, '0, rdy);
  endtask

  initial begin
    logic [31:0] pc, tgt, npc;
    bit          br, tk, v, rdy;
    #2;
    do_reset();

    // Correctly predicted taken branch
    step(1, 32'h1c000010, 1, 1, 32'h1c000100, 32'h1c000100, 0);
    check("tp1_no_redirect", redirect_o, 0);
    check("tp1_valid", update_valid_o, 1);
    check("tp1_record", update_o, mk(32'h1c000010, 32'h1c000100, 1, 0));
    idle(2, 1);

    // Not-taken branch predicted taken
    step(1, 32'h1c000020, 1, 0, 32'h1c000080, 32'h1c000080, 0);
    check("tp2_redirect", redirect_o, 1);
    check("tp2_redirect_pc", redirect_pc_o, 32'h1c000024);
    check("tp2_record", update_o, mk(32'h1c000020, 32'h1c000024, 0, 1));
    for (int unsigned i = 0; i < 3; i++)
      step(1, 32'h1c000040 + 32'(i * 4), 1, 1, 32'h1c000400, 32'h1c000400, 0);
    check("tp2_killed", m_q.size(), 1);
    step(1, 32'h1c000050, 1, 1, 32'h1c000500, 32'h1c000500, 0);
    check("tp2_resume", m_acc, 1);
    idle(3, 1);

    // False BTB hit on a non-branch
    step(1, 32'h1c000030, 0, 0, '0, 32'h1c000200, 0);
    check("tp3_redirect_pc", redirect_pc_o, 32'h1c000034);
    check("tp3_record", update_o, mk(32'h1c000030, 32'h1c000034, 0, 1));
    idle(4, 1);

    // Fill the FIFO, then hold a fifth branch until space frees up
    for (int unsigned i = 0; i < 4; i++)
      step(1, 32'h1c001000 + 32'(i * 4), 1, 1, 32'h1c002000, 32'h1c002000, 0);
    check("tp4_stall", stall_o, 1);
    step(1, 32'h1c001010, 1, 0, '0, 32'h1c001014, 0);
    check("tp4_held", m_acc, 0);
    step(1, 32'h1c001010, 1, 0, '0, 32'h1c001014, 1);
    check("tp4_stall_drop", stall_o, 0);
    step(1, 32'h1c001010, 1, 0, '0, 32'h1c001014, 0);
    check("tp4_accepted", m_acc, 1);
    idle(6, 1);

    // Reset while draining with two records queued
    step(1, 32'h1c000060, 1, 1, 32'h1c000600, 32'h1c000600, 0);
    step(1, 32'h1c000064, 1, 1, 32'h1c000700, 32'h1c000068, 0);
    step(0, '0, 0, 0, '0, '0, 0);
    do_reset();
    step(1, 32'h1c000070, 1, 1, 32'h1c000800, 32'h1c000800, 0);
    check("tp5_first_accept", update_o, mk(32'h1c000070, 32'h1c000800, 1, 0));
    idle(2, 1);

    // Wrap-around next PC
    step(1, 32'hFFFFFFFC, 0, 0, '0, 32'h00000000, 1);
    check("tp6_no_redirect", redirect_o, 0);
    idle(2, 1);

    // Randomized traffic
    for (int unsigned n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      v   = ($urandom_range(0, 3) != 0);
      pc  = $urandom & 32'hFFFF_FFFC;
      br  = $urandom_range(0, 1) == 1;
      tk  = $urandom_range(0, 1) == 1;
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) != 0) npc = (br && tk) ? tgt : pc + 32'd4;
      else                           npc = $urandom;
      rdy = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(v, pc, br, tk, tgt, npc, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bpu_resolve.md
# bpu_resolve

Back-end counterpart of the fetch-side PC generator. Takes branch outcomes resolved in execute, together with the prediction info that travelled with each instruction, and detects mispredictions. On a misprediction it issues a one-cycle redirect and flush toward fetch. It also queues predictor training records and drains them to the fetch-side `update_i` port through a valid/ready handshake.

## Interface
- `UPD_DEPTH`, 4: update FIFO entries (power of two, ≥2)
- `KILL_CYCLES`, 2: cycles of wrong-path input ignored after a redirect (≥1)
- `clk` input 1: clock
- `rst_n` input 1: reset; asynchronous, active-low
- `ex_valid_i` input 1: execute-stage instruction valid
- `ex_pc_i` input 32: instruction PC
- `ex_is_branch_i` input 1: instruction is a control-transfer op
- `ex_taken_i` input 1: resolved taken
- `ex_target_i` input 32: resolved target (meaningful when taken)
- `ex_pred_i` input `bpu_predict_info_t`: prediction carried from fetch (`.npc`)
- `stall_o` output 1: upstream must hold its instruction (FIFO full)
- `redirect_o` output 1: fetch must load `redirect_pc_o`
- `redirect_pc_o` output 32: correct next PC
- `flush_o` output 1: kill younger in-flight instructions
- `update_valid_o` output 1: training record available
- `update_o` output `bpu_update_info_t`: training record (FIFO head)
- `update_ready_i` input 1: consumer accepts the record

## Operation
- **Accept condition:** `ex_valid_i && !stall_o && state==IDLE`.
- **Actual next PC:** `ex_is_branch_i && ex_taken_i ? ex_target_i : ex_pc_i + 32'd4`. The add is 32-bit and wraps modulo 2^32.
- **Misprediction:** an accepted instruction is mispredicted when the actual next PC differs from `ex_pred_i.npc`. This includes non-branch instructions, which covers a false BTB hit.
- **Push:** an accepted instruction is pushed to the FIFO when `ex_is_branch_i`, or when it is mispredicted.
  - Record fields: `{pc=ex_pc_i, target=actual next PC, taken=ex_is_branch_i&ex_taken_i, mispredict}`.
  - A mispredicting instruction is pushed in the same cycle as its detection.
- **FSM states:**
  - `IDLE`: accept and compare instructions.
  - `REDIRECT`: `redirect_o` and `flush_o` are 1 and `redirect_pc_o` is valid. No accept. Always moves to `DRAIN` after one cycle.
  - `DRAIN`: a down-counter is loaded with `KILL_CYCLES` on entry. No accept while the counter is non-zero. Returns to `IDLE` when it reaches 1.
- **FSM transitions:** `IDLE` moves to `REDIRECT` on an accepted misprediction. `redirect_pc_o` is registered at that transition.
- **FIFO:**
  - Circular buffer with read/write pointers one bit wider than the index, giving wrap-around full/empty detection.
  - `stall_o = (count == UPD_DEPTH)`, derived from registered count only.
  - When full, no push occurs even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
- **Draining:** `update_valid_o = !empty`. `update_o` is the head entry. A pop occurs on `update_valid_o && update_ready_i`. The head is held stable while `update_ready_i` is 0.

## Timing
- **Reset values:**
  - All outputs 0, with `stall_o` 0 because the FIFO is empty.
  - FSM in `IDLE`, pointers 0.
  - Reset mid-`REDIRECT` or mid-`DRAIN` returns to `IDLE` immediately; FIFO contents are discarded.
- **Redirect:** `redirect_o`/`flush_o` rise the cycle after acceptance of the mispredicted instruction and last exactly one cycle.
- **Kill window:** inputs are ignored for `1 + KILL_CYCLES` cycles after detection.
- **Training records:** a pushed record appears on `update_o` one cycle after the push, or later if entries are ahead of it.
- **`stall_o`** changes only at clock edges, with no combinational path from `ex_*`. It may deassert the cycle after a pop.
- **Back-to-back mispredictions** cannot happen: the second one falls in the kill window and is ignored.

## Configuration
- **Macro:** `BPU_RESOLVE_PERF_EN`
- **With the macro defined:**
  - Adds 32-bit saturating counters `perf_branch_o` (accepted branches) and `perf_mispred_o` (accepted mispredictions) as extra outputs.
  - Both reset to 0.
- **Without the macro:** the counters and their ports are absent, and behaviour is otherwise identical.

## Structure
- **Shared package `bpu_pkg` holds:**
  - `bpu_predict_info_t {npc[31:0]}`.
  - `bpu_update_info_t {pc[31:0], target[31:0], taken, mispredict}`.
  - The FSM state enum `bpu_resolve_state_e` (`IDLE`, `REDIRECT`, `DRAIN`).
  - The reset PC constant `32'h1c00_0000`.
- **Sub-module:** the FIFO is natural as one, `bpu_update_fifo` (depth parameter, push/pop, full/empty); the FSM and compare logic stay in the top module.

## Test plan
- **Correct prediction:** branch pc=0x1c000010 taken, target 0x1c000100, pred npc 0x1c000100 -> no redirect; one record {0x1c000010, 0x1c000100, 1, 0} on `update_o` next cycle.
- **Not-taken mispredict:** branch pc=0x1c000020, not taken, pred npc 0x1c000080 -> `redirect_o` pulse with `redirect_pc_o`=0x1c000024; the next 3 valid inputs are ignored; record mispredict=1.
- **False BTB hit:** non-branch pc=0x1c000030 with pred npc 0x1c000200 -> redirect to 0x1c000034; record taken=0, mispredict=1.
- **Full FIFO:** `update_ready_i`=0 and 4 branches pushed -> `stall_o`=1 and a fifth branch is not accepted. Raise ready for one cycle -> `stall_o` drops the next cycle and the held branch is accepted; record order is preserved.
- **Reset mid-operation:** assert `rst_n`=0 during `DRAIN` with 2 records queued -> all outputs 0 and FIFO empty; the first instruction after release is accepted.
- **PC wrap:** pc=0xFFFFFFFC not taken, pred npc 0x00000000 -> no redirect (wrap-around add).
